// File: rtl/mul_column_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mul_column_sequencer_pkg
// Shared definitions for the multiplier column sequencer.
//   MUL_N        : default operand width
//   MUL_LATENCY  : default compressor latency (edges from shift-register
//                  outputs to compressor dst outputs)
//   seq_state_t  : sequencer FSM state encoding
//   col_height() : number of partial products in column k
//   col_skip()   : leading zero shifts for column k so that its last h(k)
//                  shifts carry the partial products
//   row_base()   : row index of the first partial product in column k
// -----------------------------------------------------------------------------
package mul_column_sequencer_pkg;

    localparam int MUL_N       = 29;
    localparam int MUL_LATENCY = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } seq_state_t;

    function automatic int col_height(input int k, input int n);
        return ((k + 1) < (2 * n - 1 - k)) ? (k + 1) : (2 * n - 1 - k);
    endfunction

    function automatic int col_skip(input int k, input int n);
        return n - col_height(k, n);
    endfunction

    function automatic int row_base(input int k, input int n);
        return ((k - n + 1) > 0) ? (k - n + 1) : 0;
    endfunction

endpackage

// File: rtl/mul_result_fifo2.sv
// -----------------------------------------------------------------------------
// mul_result_fifo2
// Two-entry FIFO holding captured products until the consumer takes them.
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset (clears storage and pointers)
//   i_push  in   write i_din (caller guarantees the FIFO is not full)
//   i_din   in   W-bit data to write
//   i_pop   in   drop the head entry (ignored when empty)
//   o_dout  out  head entry
//   o_empty out  no entries stored
//   o_full  out  both entries occupied
// -----------------------------------------------------------------------------
module mul_result_fifo2 #(
    parameter int W = 58
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_empty,
    output logic         o_full
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_do_pop;

    assign w_do_pop = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == 2'd0);
    assign o_full  = (r_count == 2'd2);

endmodule

// File: rtl/mul_column_sequencer.sv
// -----------------------------------------------------------------------------
// mul_column_sequencer
// Feeds the per-column shift registers in front of the partial-product
// compressor of an N x N unsigned multiplier and collects the product.
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   operand pair present
//   in_ready  out  operand pair accepted when in_valid && in_ready
//   in_a      in   N-bit multiplicand
//   in_b      in   N-bit multiplier
//   col_bit   out  2N-1 bits, bit k is the serial input of column k
//   dst       in   2N-bit compressor sum
//   out_valid out  product available
//   out_ready in   consumer takes product when out_valid && out_ready
//   out_data  out  2N-bit product a*b
//   busy      out  load, in-flight marker or buffered product present
// One operand pair is serialised over N load cycles; LATENCY+1 edges after
// the last load cycle the compressor sum is pushed into a 2-entry buffer.
// Credits bound accepted-but-unpopped products to the buffer depth, so a
// capture always finds room.
// -----------------------------------------------------------------------------
module mul_column_sequencer
    import mul_column_sequencer_pkg::*;
#(
    parameter int N       = MUL_N,
    parameter int LATENCY = MUL_LATENCY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic [2*N-2:0]   col_bit,
    input  logic [2*N-1:0]   dst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_data,
    output logic             busy
);

    localparam int T_W    = (N > 1) ? $clog2(N) : 1;
    localparam int PIPE_W = LATENCY + 1;

    seq_state_t        r_state;
    logic [T_W-1:0]    r_t;
    logic [N-1:0]      r_a;
    logic [N-1:0]      r_b;
    logic [PIPE_W-1:0] r_vld_pipe;
    logic [1:0]        r_credits;

    logic              w_accept;
    logic              w_pop;
    logic              w_load_last;
    logic              w_capture;
    logic              w_push;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [N-1:0]      w_tsel;

    assign w_load_last = (r_state == ST_LOAD) && (r_t == T_W'(N - 1));
    // Depends only on state and credits so the producer never sees a
    // combinational path from its own in_valid.
    assign in_ready    = (r_credits != 2'd0) && ((r_state == ST_IDLE) || w_load_last);
    assign w_accept    = in_valid && in_ready;
    assign out_valid   = !w_fifo_empty;
    assign w_pop       = out_valid && out_ready;
    assign w_capture   = r_vld_pipe[LATENCY];
    assign w_push      = w_capture && !w_fifo_full;
    assign busy        = (r_state == ST_LOAD) || (r_vld_pipe != '0) || !w_fifo_empty;

    // One-hot load-cycle select; all zero outside LOAD so col_bit idles low.
    assign w_tsel = (r_state == ST_LOAD) ? (N'(1) << r_t) : '0;

    // Sequencer FSM: load counter and operand latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_t     <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_load_last) begin
                        r_t <= '0;
                        if (w_accept) begin
                            r_a <= in_a;
                            r_b <= in_b;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_t <= r_t + T_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Marker pipe: the matrix is complete after the last load edge and the
    // compressor sum appears LATENCY edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= (r_vld_pipe << 1) | PIPE_W'(w_load_last);
        end
    end

    // Credits track free buffer slots net of accepted-but-unpopped products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= 2'd2;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_credits <= r_credits - 2'd1;
                2'b01:   r_credits <= r_credits + 2'd1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Column k receives s(k) zeros, then its h(k) partial products
    // a[i] & b[k-i] with i rising from row_base(k). Each product bit has a
    // fixed load cycle, so selection is a constant AND with the one-hot t.
    for (genvar k = 0; k < 2 * N - 1; k++) begin : g_col
        localparam int H = col_height(k, N);
        localparam int S = col_skip(k, N);
        localparam int B = row_base(k, N);
        logic [N-1:0] w_pp;
        for (genvar j = 0; j < N; j++) begin : g_row
            if (j < H) begin : g_live
                assign w_pp[j] = w_tsel[S + j] & r_a[B + j] & r_b[k - B - j];
            end else begin : g_pad
                assign w_pp[j] = 1'b0;
            end
        end
        assign col_bit[k] = |w_pp;
    end

    mul_result_fifo2 #(
        .W (2 * N)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (dst),
        .i_pop   (w_pop),
        .o_dout  (out_data),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

endmodule

// File: tb/tb_mul_column_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_column_sequencer
// Directed bench: the column shift registers and a LATENCY-stage compressor
// are modelled here, fed only by col_bit, so products depend on the DUT's
// serialisation as well as its capture timing.
// -----------------------------------------------------------------------------
module tb_mul_column_sequencer;

    localparam int N       = 29;
    localparam int LATENCY = 4;
    localparam int PW      = 2 * N;
    localparam int CW      = 2 * N - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic [CW-1:0] col_bit;
    logic [PW-1:0] dst;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    mul_column_sequencer #(
        .N       (N),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .col_bit   (col_bit),
        .dst       (dst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column shift registers (no enable, no reset) and pipelined compressor.
    logic [N-1:0]  sr [CW];
    logic [PW-1:0] csum;
    logic [PW-1:0] cpipe [LATENCY];

    function automatic int tb_height(input int k);
        return (k < N) ? (k + 1) : (2 * N - 1 - k);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < CW; k++) begin
            sr[k] <= {sr[k][N-2:0], col_bit[k]};
        end
    end

    always_comb begin
        csum = '0;
        for (int k = 0; k < CW; k++) begin
            for (int j = 0; j < N; j++) begin
                if (j < tb_height(k) && sr[k][j]) begin
                    csum = csum + (PW'(1) << k);
                end
            end
        end
    end

    always @(posedge clk) begin
        cpipe[0] <= csum;
        for (int i = 1; i < LATENCY; i++) begin
            cpipe[i] <= cpipe[i-1];
        end
    end

    assign dst = cpipe[LATENCY-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            cnt;
        int            seen;
        logic [N-1:0]  m0;
        logic [N-1:0]  m56;
        logic [PW-1:0] got [$];
        logic          bad_col;
        logic          bad_busy;
        logic          bad_ov;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        m0        = '0;
        m56       = '0;

        // Reset values
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_col_bit", 64'(col_bit), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Latency: 3 x 5 accepted at edge 0, captured at edge 34
        in_valid = 1'b1; in_a = N'(3); in_b = N'(5);
        chk("lat_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0; in_a = '0; in_b = '0;
        chk("lat_busy_load", 64'(busy), 64'd1);
        chk("lat_in_ready_load", 64'(in_ready), 64'd0);
        cnt = 0;
        for (int e = 1; e <= 33; e++) begin
            tick();
            if (out_valid) cnt++;
        end
        chk("lat_early_valid", 64'(cnt), 64'd0);
        tick();
        chk("lat_valid_rise", 64'(out_valid), 64'd1);
        chk("lat_data", 64'(out_data), 64'd15);
        tick();
        chk("lat_one_cycle", 64'(out_valid), 64'd0);

        // Maximum operands
        in_valid = 1'b1; in_a = '1; in_b = '1;
        tick();
        in_valid = 1'b0;
        chk("max_cycle1_colbit", 64'(col_bit), 64'h0000_0000_1000_0000);
        for (int c = 0; c < N; c++) begin
            m0[c]  = col_bit[0];
            m56[c] = col_bit[CW-1];
            tick();
        end
        chk("max_col0_only_last", 64'(m0), 64'h1000_0000);
        chk("max_col56_only_last", 64'(m56), 64'h1000_0000);
        repeat (4) tick();
        chk("max_not_yet", 64'(out_valid), 64'd0);
        tick();
        chk("max_valid", 64'(out_valid), 64'd1);
        chk("max_data", 64'(out_data), 64'h03FF_FFFF_C000_0001);
        tick();

        // Back-to-back with out_ready low
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = N'(1); in_b = N'(1);
        chk("b2b_first_ready", 64'(in_ready), 64'd1);
        tick();
        in_a = N'(2); in_b = N'(3);
        cnt = 0;
        for (int e = 0; e <= 27; e++) begin
            if (in_ready) cnt++;
            tick();
        end
        chk("b2b_no_ready_midload", 64'(cnt), 64'd0);
        chk("b2b_ready_last_cycle", 64'(in_ready), 64'd1);
        tick();
        in_a = N'(7); in_b = N'(9);
        cnt = 0;
        for (int e = 30; e <= 70; e++) begin
            tick();
            if (in_ready) cnt++;
        end
        chk("b2b_ready_held_low", 64'(cnt), 64'd0);
        chk("b2b_head_valid", 64'(out_valid), 64'd1);
        chk("b2b_head_data", 64'(out_data), 64'd1);
        chk("b2b_busy_buffered", 64'(busy), 64'd1);
        out_ready = 1'b1;
        chk("b2b_pop_cycle_refused", 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b0;
        chk("b2b_ready_after_pop", 64'(in_ready), 64'd1);
        chk("b2b_second_head", 64'(out_data), 64'd6);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int e = 0; e < 45; e++) begin
            if (out_valid) got.push_back(out_data);
            tick();
        end
        chk("b2b_pop_count", 64'(got.size()), 64'd2);
        chk("b2b_order_0", 64'((got.size() > 0) ? got[0] : '1), 64'd6);
        chk("b2b_order_1", 64'((got.size() > 1) ? got[1] : '1), 64'd63);

        // Credit cap after idle pops on empty buffer
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = N'(2); in_b = N'(2);
        chk("cred_ready_full", 64'(in_ready), 64'd1);
        tick();
        in_a = N'(3); in_b = N'(3);
        repeat (28) tick();
        chk("cred_ready_last", 64'(in_ready), 64'd1);
        tick();
        in_a = N'(5); in_b = N'(5);
        cnt = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (in_ready) cnt++;
        end
        chk("cred_capped", 64'(cnt), 64'd0);
        chk("cred_head_4", 64'(out_data), 64'd4);
        out_ready = 1'b1;
        chk("cred_pop_cycle_refused", 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b0;
        chk("cred_head_9", 64'(out_data), 64'd9);
        chk("cred_ready_after_pop", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;

        // Reset during load cycle 10 with a product still buffered
        repeat (9) tick();
        chk("rmid_busy", 64'(busy), 64'd1);
        chk("rmid_buffered", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_in_ready", 64'(in_ready), 64'd1);
        chk("rmid_out_valid", 64'(out_valid), 64'd0);
        chk("rmid_out_data", 64'(out_data), 64'd0);
        chk("rmid_col_bit", 64'(col_bit), 64'd0);
        chk("rmid_busy_clr", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = N'(4); in_b = N'(4);
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        seen = 0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            if (out_valid) begin
                seen = e;
                break;
            end
        end
        chk("post_rst_latency", 64'(seen), 64'd34);
        chk("post_rst_data", 64'(out_data), 64'd16);
        tick();

        // Idle
        bad_col = 1'b0; bad_busy = 1'b0; bad_ov = 1'b0;
        for (int e = 0; e < 100; e++) begin
            tick();
            if (col_bit != '0) bad_col = 1'b1;
            if (busy) bad_busy = 1'b1;
            if (out_valid) bad_ov = 1'b1;
        end
        chk("idle_col_bit", 64'(bad_col), 64'd0);
        chk("idle_busy", 64'(bad_busy), 64'd0);
        chk("idle_out_valid", 64'(bad_ov), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_column_sequencer.md
# mul_column_sequencer

Sequencer that feeds the column shift register in front of the pipelined partial-product compressor of the N×N multiplier. It accepts operand pairs over a valid/ready handshake and generates the AND partial-product bits for each of the 2N−1 columns. It serialises those bits into the column shift registers over N cycles, then captures the compressor's 2N-bit sum after a fixed pipeline latency. Products are returned through a 2-entry output buffer whose credits guarantee that no captured result is ever dropped.

## Interface
- N, 29, operand width; column k has height h(k) = min(k+1, 2N−1−k).
- LATENCY, 4, clock edges from the shift-register outputs to the compressor dst outputs (0 = combinational compressor).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  operand pair accepted when in_valid && in_ready.
- in_a  in  N  multiplicand.
- in_b  in  N  multiplier.
- col_bit  out  2N−1  bit k drives the serial input of column k's shift register.
- dst  in  2N  concatenated compressor outputs {dstK}.
- out_valid  out  1  product available.
- out_ready  in  1  consumer takes product when out_valid && out_ready.
- out_data  out  2N  product a*b.
- busy  out  1  a load or in-flight product exists.

## Operation
- FSM states:
  - IDLE: col_bit = 0, in_ready = (credits > 0).
  - LOAD: counter t = 0..N−1.
- Accept in IDLE, or in LOAD at t = N−1 for back-to-back loading. On accept: latch a and b, decrement credit, enter LOAD with t = 0.
- LOAD cycle t drives col_bit[k]:
  - With s(k) = N − h(k): if t < s(k), drive 0.
  - Otherwise j = t − s(k), i = max(0, k−N+1) + j, drive a[i] & b[k−i].
  - After N shifts each column register holds exactly its h(k) partial products.
- At t = N−1 with no accept, return to IDLE.
- At the end of each load, a marker enters a (LATENCY+1)-deep valid pipe. When the marker emerges, the sequencer pushes dst into the output buffer.
- Credits:
  - Counter 0..2, reset to 2.
  - Decremented on accept, incremented on output pop.
  - Simultaneous accept and pop leave it unchanged.
  - Capture never meets a full buffer.
- The output buffer is a FIFO. out_data = head, out_valid = not empty.
- busy = (state == LOAD) | (valid pipe ≠ 0) | (buffer not empty).
- Width rule: the product is unsigned. dst is taken modulo 2^2N; no truncation occurs for N-bit operands.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, col_bit = 0, busy = 0, FSM = IDLE, credits = 2, valid pipe cleared.
- With accept at edge E0, load cycles are E0+1..E0+N. The matrix is complete at the compressor inputs during cycle N+1, the sequencer captures at edge E0+N+1+LATENCY, and out_valid rises the cycle after that edge.
- Throughput is one product per N cycles when out_ready is held high.
- The matrix is valid at the compressor for exactly one cycle, because the shift register has no enable. The sequencer therefore never stalls mid-load.
- in_ready is combinational from the FSM state and credits only, never from in_valid.
- Reset mid-operation discards the load, in-flight markers and buffered results. Stale shift-register contents are harmless, because every column height is ≤ N and the next load fully overwrites them.

## Structure
- Shared package: N, LATENCY default, and functions col_height(k), col_skip(k) and row_base(k).
- One sub-module, mul_result_fifo2: a 2-entry, 2N-bit FIFO with push and pop, async active-low reset, and empty/full flags.
- The FSM, counter, valid pipe and credit logic live in the top module.

## Test plan
- Latency, with N=29, LATENCY=4, out_ready=1: a=3, b=5 accepted at edge 0 → out_valid rises in cycle 35, out_data=15, one cycle wide.
- Maximum operands: a=b=2^29−1 → out_data=0x03FFFFFFC0000001. Also check that during load cycle 1 only col_bit[28] is nonzero: column height 29 gives zero skip, so column 28 carries a[0]&b[28]. Columns 0 and 56 are nonzero only on load cycle 29.
- Back-to-back: three pairs (1×1, 2×3, 7×9) offered continuously with out_ready=0:
  - The first two are accepted at edges 0 and 29.
  - in_ready stays 0 after the second accept.
  - After one pop, the third is accepted.
  - Results come out in order: 1, 6, 63.
- Simultaneous pop and accept at the same edge with credits = 0: pop frees a credit in the next cycle and accept is refused in the current one. Also check the credit count is never exceeded.
- Reset mid-load: assert rst_n=0 at load cycle 10 → all outputs return to reset values asynchronously. A subsequent 4×4 gives out_data=16.
- Idle: no in_valid for 100 cycles → col_bit=0, busy=0, out_valid=0 throughout.
